// File: rtl/ha_token_fifo_nch.sv
// Multi-channel token buffer: NUM_CH independent circular FIFOs with valid/ready on both sides,
// plus an optional join mode that releases one token from every channel at once.
module ha_token_fifo_nch #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      join_en,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH*WIDTH-1:0]   in_data,
  output logic [NUM_CH-1:0]         out_valid,
  input  logic [NUM_CH-1:0]         out_ready,
  output logic [NUM_CH*WIDTH-1:0]   out_data,
  output logic [NUM_CH*CNT_W-1:0]   occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [NUM_CH][DEPTH];
  logic [PTR_W-1:0] rd_q  [NUM_CH];
  logic [PTR_W-1:0] rd_d  [NUM_CH];
  logic [PTR_W-1:0] wr_q  [NUM_CH];
  logic [PTR_W-1:0] wr_d  [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  logic [NUM_CH-1:0] not_empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              all_ne;
  logic              join_pop;

  always_comb begin
    all_ne = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      not_empty[i] = (cnt_q[i] != '0);
      all_ne       = all_ne & not_empty[i];
    end
    join_pop = all_ne & (&out_ready);

    for (int unsigned i = 0; i < NUM_CH; i++) begin
      in_ready[i]  = (cnt_q[i] != CNT_FULL);
      out_valid[i] = join_en ? all_ne : not_empty[i];
      pop[i]       = join_en ? join_pop : (not_empty[i] & out_ready[i]);
      push[i]      = in_valid[i] & in_ready[i];

      out_data[i*WIDTH +: WIDTH] = mem_q[i][rd_q[i]];
      occ[i*CNT_W +: CNT_W]      = cnt_q[i];

      rd_d[i]  = pop[i]  ? rd_q[i] + PTR_ONE : rd_q[i];
      wr_d[i]  = push[i] ? wr_q[i] + PTR_ONE : wr_q[i];
      cnt_d[i] = cnt_q[i];
      if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + CNT_ONE;
      else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - CNT_ONE;

      // Flush wins over any push/pop offered in the same cycle.
      if (flush) begin
        rd_d[i]  = '0;
        wr_d[i]  = '0;
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        rd_q[i]  <= rd_d[i];
        wr_q[i]  <= wr_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Storage carries no reset; contents are only observable once counted.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (push[i] && !flush) mem_q[i][wr_q[i]] <= in_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_ha_token_fifo_nch.sv
// Scoreboard bench for ha_token_fifo_nch: per-channel expected-token queues filled on accepted
// pushes and drained/compared on pops, plus occupancy and handshake checks every cycle.
module tb_ha_token_fifo_nch;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int D   = 4;
  localparam int CW  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              join_en;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH*W-1:0]  in_data;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*W-1:0]  out_data;
  logic [NCH*CW-1:0] occ;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] sb [NCH][$];

  ha_token_fifo_nch #(.NUM_CH(NCH), .WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .join_en(join_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check outputs against the model, then advance model and DUT by one clock edge.
  task automatic tick();
    logic [NCH-1:0] exp_rdy, exp_vld, pop;
    bit all_ne;
    #2;
    all_ne = 1'b1;
    for (int i = 0; i < NCH; i++) if (sb[i].size() == 0) all_ne = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      exp_rdy[i] = (sb[i].size() != D);
      exp_vld[i] = join_en ? all_ne : (sb[i].size() != 0);
    end
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(exp_vld));
    for (int i = 0; i < NCH; i++)
      chk($sformatf("occ%0d", i), 64'(occ[i*CW +: CW]), 64'(sb[i].size()));
    if (join_en) pop = (all_ne && (&out_ready)) ? '1 : '0;
    else         pop = exp_vld & out_ready;
    for (int i = 0; i < NCH; i++) begin
      if (exp_vld[i]) chk($sformatf("data%0d", i), 64'(out_data[i*W +: W]), 64'(sb[i][0]));
      if (pop[i]) void'(sb[i].pop_front());
    end
    if (flush) begin
      for (int i = 0; i < NCH; i++) sb[i].delete();
    end else begin
      for (int i = 0; i < NCH; i++)
        if (in_valid[i] && exp_rdy[i]) sb[i].push_back(in_data[i*W +: W]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = '0; out_ready = '0; in_data = '0;
  endtask

  initial begin
    rst = 1'b0; join_en = 1'b0;
    idle_inputs();
    in_valid = '1;
    in_data  = {32'hEE03, 32'hEE02, 32'hEE01, 32'hEE00};
    out_ready = '1;

    // Reset held with producers active
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_in_ready", 64'(in_ready), 64'hF);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_occ", 64'(occ), 64'h0);
    end
    idle_inputs();
    #3 rst = 1'b1;
    @(posedge clk); #1;
    repeat (2) tick();

    // Fill ch0 past capacity, then drain
    for (int k = 0; k < 5; k++) begin
      in_valid = 4'b0001;
      in_data[31:0] = 32'hA0 + 32'(k);
      tick();
    end
    idle_inputs();
    chk("occ0_full", 64'(occ[CW-1:0]), 64'd4);
    out_ready = 4'b0001;
    repeat (5) tick();

    // Stream through full ch1 across pointer wrap
    for (int k = 0; k < 4; k++) begin
      in_valid = 4'b0010; in_data[63:32] = 32'hB0 + 32'(k); tick();
    end
    out_ready = 4'b0010;
    for (int k = 4; k < 14; k++) begin
      in_valid = 4'b0010; in_data[63:32] = 32'hB0 + 32'(k); tick();
    end
    idle_inputs(); out_ready = 4'b0010;
    repeat (6) tick();
    idle_inputs();

    // Join barrier
    join_en = 1'b1;
    in_valid = 4'b0111; in_data = {32'h0, 32'hD2, 32'hD1, 32'hD0};
    tick();
    idle_inputs(); tick();
    in_valid = 4'b1000; in_data[127:96] = 32'hD3; tick();
    idle_inputs();
    out_ready = 4'hE; tick();
    out_ready = 4'hF; tick();
    idle_inputs(); tick();
    join_en = 1'b0;

    // Flush with mixed occupancy and a concurrent push on ch3
    for (int k = 0; k < 3; k++) begin
      in_valid = (k < 1) ? 4'b0111 : (k < 2) ? 4'b0101 : 4'b0100;
      in_data = {32'h0, 32'hC20 + 32'(k), 32'hC10 + 32'(k), 32'hC00 + 32'(k)};
      tick();
    end
    idle_inputs();
    flush = 1'b1; in_valid = 4'b1000; in_data[127:96] = 32'hDEAD; tick();
    idle_inputs(); tick();
    chk("flush_occ", 64'(occ), 64'h0);

    // Async reset mid-drain
    for (int k = 0; k < 3; k++) begin
      in_valid = 4'b0001; in_data[31:0] = 32'hF0 + 32'(k); tick();
    end
    idle_inputs(); out_ready = 4'b0001; tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_occ", 64'(occ), 64'h0);
    chk("arst_in_ready", 64'(in_ready), 64'hF);
    for (int i = 0; i < NCH; i++) sb[i].delete();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    idle_inputs(); tick();

    // Random traffic with join toggling and occasional flush
    for (int k = 0; k < 400; k++) begin
      in_valid  = 4'($urandom);
      out_ready = 4'($urandom);
      join_en   = ($urandom_range(0, 9) == 0) ? ~join_en : join_en;
      flush     = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NCH; i++) in_data[i*W +: W] = $urandom;
      tick();
    end
    idle_inputs(); join_en = 1'b0; out_ready = '1;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
